substitui_bytes_inv: RTL
========================

SUBSTITUI_BYTES_INV -- requirements
Module: substitui_bytes_inv

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 bloco  input  128  ciphertext-side state to inverse-substitute; byte i = bloco[8i+7:8i].
REQ-004 entrada_valida  input  1  bloco is valid this cycle.
REQ-005 entrada_pronta  output  1  block can accept a new bloco this cycle.
REQ-006 saida  output  128  result; byte i = InvSbox(bloco byte i) (AES FIPS-197 inverse S-box).
REQ-007 saida_valida  output  1  saida holds a complete result.
REQ-008 saida_pronta  input  1  consumer takes saida this cycle.

Function
REQ-009 The FSM SHALL have three states: OCIOSO, PROCESSA and PRONTO.
REQ-010 In OCIOSO: entrada_pronta = 1 and saida_valida = 0.
REQ-011 In OCIOSO, entrada_valida = 1 SHALL cause the following at that edge:
  - capture bloco into the internal state register;
  - clear the lane counter;
  - go to PROCESSA.
REQ-012 In PROCESSA, each edge SHALL replace L bytes (lanes) in place with their InvSbox value, starting at byte 0 and ascending; the counter SHALL advance by 1.
REQ-013 PROCESSA SHALL last exactly 16/L clocks. On the edge that processes the last lane, the FSM SHALL go to PRONTO.
REQ-014 Latency SHALL be exactly 16/L clocks: saida_valida is high in the cycle 16/L edges after the accepting edge.
REQ-015 entrada_pronta SHALL be 0 in PROCESSA and PRONTO; entrada_valida and bloco changes are ignored there.
REQ-016 In PRONTO: saida_valida = 1 and saida is stable until accepted.
REQ-017 In PRONTO, saida_pronta = 1 SHALL return the FSM to OCIOSO; saida_pronta = 0 holds PRONTO indefinitely.
REQ-018 A new block SHALL never be accepted in the same cycle as a result hand-off. Minimum initiation interval is 16/L + 2 clocks.
REQ-019 saida SHALL be driven from the state register at all times; its value outside PRONTO carries no meaning.
REQ-020 The lane counter SHALL be wide enough for 16/L values and SHALL NOT wrap within one block.
REQ-021 The inverse S-box SHALL be a combinational 256-entry lookup; L copies SHALL be instantiated.

Reset
REQ-022 While rst_n = 0 at an edge, the block SHALL go to OCIOSO with state register = 0 and counter = 0. The outputs are then entrada_pronta = 1, saida_valida = 0 and saida = 0.
REQ-023 Reset during PROCESSA or PRONTO SHALL discard the block in flight with no partial result presented.
REQ-024 rst_n SHALL take priority over every handshake input in the same cycle.

Configuration
REQ-025 Macro SUBSTITUI_BYTES_INV_QUATRO_LANES_EN selects the lane count L:
  - defined: L = 4, 4 processing clocks;
  - undefined: L = 1, 16 processing clocks.
  Interface and results SHALL be identical in both builds; only latency differs.

Verification
REQ-026 bloco=53832983b10083206eed206e1a3b5a00, entrada_valida pulse -> saida=50414c41565241544553544543494652, saida_valida after exactly 16 clocks (4 with macro).
REQ-027 bloco=0 -> saida=52525252525252525252525252525252; bloco=63636363636363636363636363636363 -> saida=0.
REQ-028 Hold saida_pronta=0 for 10 clocks in PRONTO while toggling entrada_valida and bloco -> saida stable, saida_valida=1, entrada_pronta=0, no new capture.
REQ-029 rst_n=0 at the 3rd clock of PROCESSA -> next cycle OCIOSO, saida=0, saida_valida=0. The next block is processed correctly from scratch.
REQ-030 Two back-to-back blocks with saida_pronta tied to 1 -> second accepted one cycle after hand-off, both results correct, interval 18 clocks (6 with macro).

Source files
------------

// File: rtl/substitui_bytes_inv.sv
// AES inverse SubBytes over a 128-bit block, L bytes per clock with a ready/valid handshake.
// Define SUBSTITUI_BYTES_INV_QUATRO_LANES_EN for 4 lanes (4 clocks); default is 1 lane (16 clocks).
module substitui_bytes_inv (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] bloco,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  output logic [127:0] saida,
  output logic         saida_valida,
  input  logic         saida_pronta
);

`ifdef SUBSTITUI_BYTES_INV_QUATRO_LANES_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif
  localparam int DATA_W = 128;
  localparam int STAGES = 16 / LANES;
  // One spare count value so the counter can step past the last lane without wrapping.
  localparam int CNT_W = $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(STAGES - 1);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  typedef enum logic [1:0] {OCIOSO, PROCESSA, PRONTO} estado_t;

  estado_t           estado;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] reg_estado;
  logic [DATA_W-1:0] reg_estado_nxt;
  logic [3:0]        base;
  logic [3:0]        lane_idx [LANES];
  logic [7:0]        lane_in  [LANES];
  logic [7:0]        lane_out [LANES];

  assign base = 4'(cnt * LANES);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_idx[j] = base + 4'(j);
    assign lane_in[j]  = reg_estado[{lane_idx[j], 3'b000} +: 8];
    assign lane_out[j] = inv_sbox(lane_in[j]);
  end

  always_comb begin
    reg_estado_nxt = reg_estado;
    for (int j = 0; j < LANES; j++) begin
      reg_estado_nxt[{lane_idx[j], 3'b000} +: 8] = lane_out[j];
    end
  end

  assign saida = reg_estado;

  // Control and state register; reset clears the block in flight so no partial result escapes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado         <= OCIOSO;
      cnt            <= '0;
      reg_estado     <= '0;
      entrada_pronta <= 1'b1;
      saida_valida   <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (entrada_valida) begin
            reg_estado     <= bloco;
            cnt            <= '0;
            estado         <= PROCESSA;
            entrada_pronta <= 1'b0;
          end
        end
        PROCESSA: begin
          reg_estado <= reg_estado_nxt;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == ULTIMO) begin
            estado       <= PRONTO;
            saida_valida <= 1'b1;
          end
        end
        PRONTO: begin
          if (saida_pronta) begin
            estado         <= OCIOSO;
            saida_valida   <= 1'b0;
            entrada_pronta <= 1'b1;
          end
        end
        default: begin
          estado         <= OCIOSO;
          entrada_pronta <= 1'b1;
          saida_valida   <= 1'b0;
        end
      endcase
    end
  end

endmodule
